// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: arbitrates jumps, divider stalls and load-use bubbles.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int AW           = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int LU_CYCLES    = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_req_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          ld_use_i,
  input  logic          div_busy_i,
  output logic          jump_flag_o,
  output logic [AW-1:0] jump_addr_o,
  output logic          pc_hold_o,
  output logic          if_id_hold_o,
  output logic          id_ex_hold_o,
  output logic          if_id_flush_o,
  output logic          id_ex_flush_o,
  output logic          div_abort_o,
  output logic [1:0]    state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]   perf_jump_o,
  output logic [31:0]   perf_stall_o,
  output logic [31:0]   perf_flush_o
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FLUSH     = 2'd1,
    LU_STALL  = 2'd2,
    DIV_STALL = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] LU_INIT    = 4'(LU_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Priority jump > divider > load-use; outputs are all zero while reset is held low.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    jump_flag_o   = 1'b0;
    jump_addr_o   = '0;
    pc_hold_o     = 1'b0;
    if_id_hold_o  = 1'b0;
    id_ex_hold_o  = 1'b0;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    div_abort_o   = 1'b0;
    state_o       = r_state;

    if (!rst) begin
      state_o      = 2'd0;
      w_next_state = IDLE;
      w_next_cnt   = 4'd0;
    end else if (jump_req_i) begin
      jump_flag_o   = 1'b1;
      jump_addr_o   = jump_addr_i;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      div_abort_o   = div_busy_i;
      if (FLUSH_CYCLES > 1) begin
        w_next_state = FLUSH;
        w_next_cnt   = FLUSH_INIT;
      end else begin
        w_next_state = IDLE;
        w_next_cnt   = 4'd0;
      end
    end else begin
      case (r_state)
        IDLE, LU_STALL: begin
          if (div_busy_i) begin
            pc_hold_o    = 1'b1;
            if_id_hold_o = 1'b1;
            id_ex_hold_o = 1'b1;
            w_next_state = DIV_STALL;
            w_next_cnt   = 4'd0;
          end else if (r_state == LU_STALL || ld_use_i) begin
            // Bubble: freeze PC and IF/ID, squash what would enter EX.
            pc_hold_o     = 1'b1;
            if_id_hold_o  = 1'b1;
            id_ex_flush_o = 1'b1;
            if (r_state == IDLE) begin
              if (LU_CYCLES > 1) begin
                w_next_state = LU_STALL;
                w_next_cnt   = LU_INIT;
              end else begin
                w_next_state = IDLE;
                w_next_cnt   = 4'd0;
              end
            end else if (r_cnt <= 4'd1) begin
              w_next_state = IDLE;
              w_next_cnt   = 4'd0;
            end else begin
              w_next_cnt = r_cnt - 4'd1;
            end
          end
        end
        FLUSH: begin
          if_id_flush_o = 1'b1;
          id_ex_flush_o = 1'b1;
          if (r_cnt <= 4'd1) begin
            w_next_state = IDLE;
            w_next_cnt   = 4'd0;
          end else begin
            w_next_cnt = r_cnt - 4'd1;
          end
        end
        DIV_STALL: begin
          if (div_busy_i) begin
            pc_hold_o    = 1'b1;
            if_id_hold_o = 1'b1;
            id_ex_hold_o = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
          w_next_cnt = 4'd0;
        end
        default: begin
          w_next_state = IDLE;
          w_next_cnt   = 4'd0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_perf_jump;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_jump  <= 32'd0;
      r_perf_stall <= 32'd0;
      r_perf_flush <= 32'd0;
    end else begin
      if (jump_flag_o)   r_perf_jump  <= r_perf_jump + 32'd1;
      if (pc_hold_o)     r_perf_stall <= r_perf_stall + 32'd1;
      if (id_ex_flush_o) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign perf_jump_o  = r_perf_jump;
  assign perf_stall_o = r_perf_stall;
  assign perf_flush_o = r_perf_flush;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus one with LU_CYCLES=3, FLUSH_CYCLES=1.
// Observed vector layout: {state[1:0], jump_flag, pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, div_abort}.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  int          errors;
  int          checks;

  logic        a_jump_req, a_ld_use, a_div_busy;
  logic [31:0] a_jump_addr;
  logic        a_jf, a_ph, a_ih, a_eh, a_ifl, a_efl, a_ab;
  logic [31:0] a_addr_o;
  logic [1:0]  a_st;

  logic        b_jump_req, b_ld_use, b_div_busy;
  logic [31:0] b_jump_addr;
  logic        b_jf, b_ph, b_ih, b_eh, b_ifl, b_efl, b_ab;
  logic [31:0] b_addr_o;
  logic [1:0]  b_st;

  logic [8:0]  obs_a, obs_b;
  assign obs_a = {a_st, a_jf, a_ph, a_ih, a_eh, a_ifl, a_efl, a_ab};
  assign obs_b = {b_st, b_jf, b_ph, b_ih, b_eh, b_ifl, b_efl, b_ab};

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] a_pj, a_ps, a_pf, b_pj, b_ps, b_pf;
`endif

  pipe_ctrl u_dut_a (
    .clk(clk), .rst(rst),
    .jump_req_i(a_jump_req), .jump_addr_i(a_jump_addr),
    .ld_use_i(a_ld_use), .div_busy_i(a_div_busy),
    .jump_flag_o(a_jf), .jump_addr_o(a_addr_o),
    .pc_hold_o(a_ph), .if_id_hold_o(a_ih), .id_ex_hold_o(a_eh),
    .if_id_flush_o(a_ifl), .id_ex_flush_o(a_efl),
    .div_abort_o(a_ab), .state_o(a_st)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_jump_o(a_pj), .perf_stall_o(a_ps), .perf_flush_o(a_pf)
`endif
  );

  pipe_ctrl #(.AW(32), .FLUSH_CYCLES(1), .LU_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .jump_req_i(b_jump_req), .jump_addr_i(b_jump_addr),
    .ld_use_i(b_ld_use), .div_busy_i(b_div_busy),
    .jump_flag_o(b_jf), .jump_addr_o(b_addr_o),
    .pc_hold_o(b_ph), .if_id_hold_o(b_ih), .id_ex_hold_o(b_eh),
    .if_id_flush_o(b_ifl), .id_ex_flush_o(b_efl),
    .div_abort_o(b_ab), .state_o(b_st)
`ifdef PIPE_CTRL_PERF_EN
    , .perf_jump_o(b_pj), .perf_stall_o(b_ps), .perf_flush_o(b_pf)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    a_jump_req = 1'b1; a_jump_addr = 32'hDEAD_BEEF; a_ld_use = 1'b1; a_div_busy = 1'b1;
    b_jump_req = 1'b1; b_jump_addr = 32'h1234_5678; b_ld_use = 1'b1; b_div_busy = 1'b0;
    tick(); tick();
    #1;
    checks++; if (obs_a !== 9'd0) begin errors++; $display("FAIL reset_outs_a got=%b exp=%b", obs_a, 9'd0); end
    checks++; if (a_addr_o !== 32'd0) begin errors++; $display("FAIL reset_addr_a got=%h exp=%h", a_addr_o, 32'd0); end
    checks++; if (obs_b !== 9'd0) begin errors++; $display("FAIL reset_outs_b got=%b exp=%b", obs_b, 9'd0); end
    tick();
    rst = 1'b1;
    a_jump_req = 1'b0; a_jump_addr = 32'd0; a_ld_use = 1'b0; a_div_busy = 1'b0;
    b_jump_req = 1'b0; b_jump_addr = 32'd0; b_ld_use = 1'b0; b_div_busy = 1'b0;
    #1;
    checks++; if (obs_a !== 9'd0) begin errors++; $display("FAIL reset_idle_a got=%b exp=%b", obs_a, 9'd0); end
  endtask

  task automatic test_jump();
    logic [8:0] exp_v [3];
    exp_v[0] = 9'b00_1000110;
    exp_v[1] = 9'b01_0000110;
    exp_v[2] = 9'b00_0000000;
    tick();
    a_jump_req = 1'b1; a_jump_addr = 32'h0000_0100;
    #1;
    checks++; if (a_addr_o !== 32'h100) begin errors++; $display("FAIL jump_addr got=%h exp=%h", a_addr_o, 32'h100); end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin tick(); a_jump_req = 1'b0; a_jump_addr = 32'd0; #1; end
      checks++; if (obs_a !== exp_v[i]) begin errors++; $display("FAIL jump_c%0d got=%b exp=%b", i, obs_a, exp_v[i]); end
    end
    // FLUSH_CYCLES=1: no FLUSH state after the jump cycle
    tick();
    b_jump_req = 1'b1; b_jump_addr = 32'h0000_0040;
    #1;
    checks++; if (obs_b !== 9'b00_1000110) begin errors++; $display("FAIL jump1_c0 got=%b exp=%b", obs_b, 9'b00_1000110); end
    tick(); b_jump_req = 1'b0; #1;
    checks++; if (obs_b !== 9'd0) begin errors++; $display("FAIL jump1_c1 got=%b exp=%b", obs_b, 9'd0); end
  endtask

  task automatic test_load_use();
    logic [8:0] exp_v [4];
    tick(); a_ld_use = 1'b1; #1;
    checks++; if (obs_a !== 9'b00_0110010) begin errors++; $display("FAIL lu1_c0 got=%b exp=%b", obs_a, 9'b00_0110010); end
    tick(); a_ld_use = 1'b0; #1;
    checks++; if (obs_a !== 9'd0) begin errors++; $display("FAIL lu1_c1 got=%b exp=%b", obs_a, 9'd0); end
    exp_v[0] = 9'b00_0110010;
    exp_v[1] = 9'b10_0110010;
    exp_v[2] = 9'b10_0110010;
    exp_v[3] = 9'b00_0000000;
    tick(); b_ld_use = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin tick(); b_ld_use = 1'b0; #1; end
      checks++; if (obs_b !== exp_v[i]) begin errors++; $display("FAIL lu3_c%0d got=%b exp=%b", i, obs_b, exp_v[i]); end
    end
    // divider arriving during LU_STALL takes over
    tick(); b_ld_use = 1'b1; #1;
    tick(); b_ld_use = 1'b0; b_div_busy = 1'b1; #1;
    checks++; if (obs_b !== 9'b10_0111000) begin errors++; $display("FAIL lu_div got=%b exp=%b", obs_b, 9'b10_0111000); end
    tick(); b_div_busy = 1'b0; #1;
    checks++; if (obs_b !== 9'b11_0000000) begin errors++; $display("FAIL lu_div_rel got=%b exp=%b", obs_b, 9'b11_0000000); end
    tick(); #1;
    checks++; if (obs_b !== 9'd0) begin errors++; $display("FAIL lu_div_idle got=%b exp=%b", obs_b, 9'd0); end
  endtask

  task automatic test_divide();
    logic [8:0] exp_v [7];
    exp_v[0] = 9'b00_0111000;
    for (int i = 1; i < 5; i++) exp_v[i] = 9'b11_0111000;
    exp_v[5] = 9'b11_0000000;
    exp_v[6] = 9'b00_0000000;
    for (int i = 0; i < 7; i++) begin
      tick();
      a_div_busy = (i < 5);
      #1;
      checks++; if (obs_a !== exp_v[i]) begin errors++; $display("FAIL div_c%0d got=%b exp=%b", i, obs_a, exp_v[i]); end
    end
  endtask

  task automatic test_jump_in_div();
    tick(); a_div_busy = 1'b1; #1;
    tick(); #1;
    tick(); a_jump_req = 1'b1; a_jump_addr = 32'h0000_0200; #1;
    checks++; if (obs_a !== 9'b11_1000111) begin errors++; $display("FAIL jdiv_c0 got=%b exp=%b", obs_a, 9'b11_1000111); end
    checks++; if (a_addr_o !== 32'h200) begin errors++; $display("FAIL jdiv_addr got=%h exp=%h", a_addr_o, 32'h200); end
    tick(); a_jump_req = 1'b0; #1;
    checks++; if (obs_a !== 9'b01_0000110) begin errors++; $display("FAIL jdiv_flush got=%b exp=%b", obs_a, 9'b01_0000110); end
    tick(); #1;
    checks++; if (obs_a !== 9'b00_0111000) begin errors++; $display("FAIL jdiv_restall got=%b exp=%b", obs_a, 9'b00_0111000); end
    tick(); a_div_busy = 1'b0; #1;
    checks++; if (obs_a !== 9'b11_0000000) begin errors++; $display("FAIL jdiv_rel got=%b exp=%b", obs_a, 9'b11_0000000); end
    tick(); #1;
  endtask

  task automatic test_back_to_back();
    tick(); a_ld_use = 1'b1; a_div_busy = 1'b1; #1;
    checks++; if (obs_a !== 9'b00_0111000) begin errors++; $display("FAIL simul got=%b exp=%b", obs_a, 9'b00_0111000); end
    tick(); a_ld_use = 1'b0; a_div_busy = 1'b0; #1;
    checks++; if (obs_a !== 9'b11_0000000) begin errors++; $display("FAIL simul_rel got=%b exp=%b", obs_a, 9'b11_0000000); end
    tick(); a_jump_req = 1'b1; a_jump_addr = 32'h0000_0280; #1;
    checks++; if (obs_a !== 9'b00_1000110) begin errors++; $display("FAIL b2b_j1 got=%b exp=%b", obs_a, 9'b00_1000110); end
    tick(); a_jump_addr = 32'h0000_0300; #1;
    checks++; if (obs_a !== 9'b01_1000110) begin errors++; $display("FAIL b2b_j2 got=%b exp=%b", obs_a, 9'b01_1000110); end
    checks++; if (a_addr_o !== 32'h300) begin errors++; $display("FAIL b2b_addr got=%h exp=%h", a_addr_o, 32'h300); end
    tick(); a_jump_req = 1'b0; a_jump_addr = 32'd0; a_ld_use = 1'b1; #1;
    checks++; if (obs_a !== 9'b01_0000110) begin errors++; $display("FAIL b2b_flush got=%b exp=%b", obs_a, 9'b01_0000110); end
    tick(); a_ld_use = 1'b0; #1;
    checks++; if (obs_a !== 9'd0) begin errors++; $display("FAIL b2b_idle got=%b exp=%b", obs_a, 9'd0); end
  endtask

  task automatic test_reset_mid();
    tick(); a_div_busy = 1'b1; #1;
    tick(); rst = 1'b0; #1;
    checks++; if (obs_a !== 9'd0) begin errors++; $display("FAIL rmid_low got=%b exp=%b", obs_a, 9'd0); end
    tick(); #1;
    checks++; if (a_addr_o !== 32'd0 || obs_a !== 9'd0) begin errors++; $display("FAIL rmid_low2 got=%b exp=%b", obs_a, 9'd0); end
    tick(); rst = 1'b1; a_div_busy = 1'b0; #1;
    checks++; if (obs_a !== 9'd0) begin errors++; $display("FAIL rmid_idle got=%b exp=%b", obs_a, 9'd0); end
`ifdef PIPE_CTRL_PERF_EN
    checks++; if ({a_pj, a_ps, a_pf} !== 96'd0) begin errors++; $display("FAIL rmid_perf got=%h/%h/%h exp=0", a_pj, a_ps, a_pf); end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_jump();
    test_load_use();
    test_divide();
    test_jump_in_div();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
